// File: rtl/change_dispense_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : change_dispense_engine_pkg
// Description : Shared vending-machine definitions: FSM state encoding for
//               the change dispense engine and default sizing constants.
// Revision    : 1.0  initial release
// ============================================================================
package change_dispense_engine_pkg;

    // Default sizing shared by the vending-machine blocks
    localparam int kNumCoins  = 3;
    localparam int kTotalBits = 16;
    localparam int kWaitTime  = 10;

    // Dispense FSM encoding
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DISPENSE = 2'd1;
    localparam logic [1:0] ST_DONE     = 2'd2;

endpackage : change_dispense_engine_pkg
`default_nettype wire

// File: rtl/change_dispense_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : change_dispense_engine_if
// Description : Coin-out valid/ready handshake between the dispense engine
//               (master) and the coin mechanism (slave).
//               coin_valid : a coin is offered
//               coin_idx   : denomination index of the offered coin
//               coin_ready : mechanism accepts the offered coin
// Revision    : 1.0  initial release
// ============================================================================
interface change_dispense_engine_if #(
    parameter int IDX_W = 2
);
    logic             coin_valid;
    logic [IDX_W-1:0] coin_idx;
    logic             coin_ready;

    modport master (output coin_valid, output coin_idx, input coin_ready);
    modport slave  (input coin_valid, input coin_idx, output coin_ready);
endinterface : change_dispense_engine_if
`default_nettype wire

// File: rtl/change_dispense_engine_coin_greedy_select.sv
`default_nettype none
// ============================================================================
// Module      : change_dispense_engine_coin_greedy_select
// Description : Combinational greedy coin picker. Returns the highest index
//               whose non-zero value fits into the remaining amount. With an
//               ascending table this is the largest fitting coin.
// Ports       : i_coin_value  flattened coin table (slice i = coin i)
//               i_remaining   amount still to be covered
//               o_found       some enabled coin fits
//               o_idx         index of the chosen coin
//               o_value       value of the chosen coin (0 when none found)
// Revision    : 1.0  initial release
// ============================================================================
module change_dispense_engine_coin_greedy_select #(
    parameter int NUM_COINS  = 3,
    parameter int COIN_W     = 32,
    parameter int TOTAL_BITS = 16,
    parameter int IDX_W      = 2
) (
    input  wire logic [NUM_COINS*COIN_W-1:0] i_coin_value,
    input  wire logic [TOTAL_BITS-1:0]       i_remaining,
    output logic                             o_found,
    output logic [IDX_W-1:0]                 o_idx,
    output logic [TOTAL_BITS-1:0]            o_value
);
    // Both operands are zero-extended to a common width, so a coin wider than
    // the balance can never compare as fitting.
    localparam int CMP_W = (COIN_W > TOTAL_BITS) ? COIN_W : TOTAL_BITS;

    logic [CMP_W-1:0] w_val_ext [NUM_COINS];
    logic             w_fit     [NUM_COINS];

    generate
        for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_coin
            assign w_val_ext[gi] = CMP_W'(i_coin_value[gi*COIN_W +: COIN_W]);
            assign w_fit[gi]     = (w_val_ext[gi] != '0) &&
                                   (w_val_ext[gi] <= CMP_W'(i_remaining));
        end
    endgenerate

    // Later (higher) indices override earlier ones: highest fitting index wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        o_value = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (w_fit[i]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
                o_value = w_val_ext[i][TOTAL_BITS-1:0];
            end
        end
    end

endmodule : change_dispense_engine_coin_greedy_select
`default_nettype wire

// File: rtl/change_dispense_engine.sv
`default_nettype none
// ============================================================================
// Module      : change_dispense_engine
// Description : Inactivity timer plus greedy change return. On a return
//               trigger the balance is latched and paid out one coin per
//               valid/ready handshake, largest fitting coin first.
// Ports       : clk, reset        clock, async active-high reset
//               i_coin_value      flattened denomination table
//               i_balance         customer balance from the datapath
//               i_activity        coin insert / vend pulse
//               i_return_req      return button pulse
//               coin (master)     coin_valid / coin_idx / coin_ready
//               o_busy            high in DISPENSE and DONE
//               o_done            one-cycle completion pulse
//               o_return_total    sum of accepted coins, held
//               o_residue         uncoverable remainder, held
//               o_wait_time       current inactivity timer value
// Revision    : 1.0  initial release
// ============================================================================
module change_dispense_engine
    import change_dispense_engine_pkg::*;
#(
    parameter int NUM_COINS   = kNumCoins,
    parameter int COIN_W      = 32,
    parameter int TOTAL_BITS  = kTotalBits,
    parameter int WAIT_CYCLES = kWaitTime,
    parameter int IDX_W       = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1
) (
    input  wire logic                        clk,
    input  wire logic                        reset,
    input  wire logic [NUM_COINS*COIN_W-1:0] i_coin_value,
    input  wire logic [TOTAL_BITS-1:0]       i_balance,
    input  wire logic                        i_activity,
    input  wire logic                        i_return_req,
    change_dispense_engine_if.master         coin,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [TOTAL_BITS-1:0]            o_return_total,
    output logic [TOTAL_BITS-1:0]            o_residue,
    output logic [31:0]                      o_wait_time
);

    logic [1:0]            r_state;
    logic [31:0]           r_timer;
    logic [TOTAL_BITS-1:0] r_remaining;
    logic [TOTAL_BITS-1:0] r_total;
    logic [TOTAL_BITS-1:0] r_residue;
    logic                  r_act_seen;   // activity observed since last return

    logic                  w_found;
    logic [IDX_W-1:0]      w_idx;
    logic [TOTAL_BITS-1:0] w_value;
    logic                  w_trigger;

    change_dispense_engine_coin_greedy_select #(
        .NUM_COINS  (NUM_COINS),
        .COIN_W     (COIN_W),
        .TOTAL_BITS (TOTAL_BITS),
        .IDX_W      (IDX_W)
    ) u_select (
        .i_coin_value (i_coin_value),
        .i_remaining  (r_remaining),
        .o_found      (w_found),
        .o_idx        (w_idx),
        .o_value      (w_value)
    );

    // The return button always wins over a coincident activity pulse. A
    // timeout is the decrement from 1 to 0 without a reload in that cycle.
    // A balance that shows up with the timer already at 0 and no activity
    // since the last return is paid out straight away.
    assign w_trigger = (r_state == ST_IDLE) &&
                       (i_return_req ||
                        ((r_timer == 32'd1) && !i_activity) ||
                        ((r_timer == 32'd0) && (i_balance != '0) &&
                         !r_act_seen && !i_activity));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_remaining <= '0;
            r_total     <= '0;
            r_residue   <= '0;
            r_act_seen  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_state     <= ST_DISPENSE;
                        r_timer     <= '0;
                        r_remaining <= i_balance;
                        r_total     <= '0;
                        r_residue   <= '0;
                        r_act_seen  <= 1'b0;
                    end else if (i_activity) begin
                        r_timer    <= 32'(WAIT_CYCLES);
                        r_act_seen <= 1'b1;
                    end else if (r_timer != '0) begin
                        r_timer <= r_timer - 32'd1;
                    end
                end
                ST_DISPENSE: begin
                    // Remaining only moves on a handshake, so an unaccepted
                    // offer keeps the same selection on the next cycle.
                    if (!w_found) begin
                        r_state   <= ST_DONE;
                        r_residue <= r_remaining;
                    end else if (coin.coin_ready) begin
                        r_remaining <= r_remaining - w_value;
                        r_total     <= r_total + w_value;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_timer <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign coin.coin_valid = (r_state == ST_DISPENSE) && w_found;
    assign coin.coin_idx   = coin.coin_valid ? w_idx : '0;
    assign o_busy          = (r_state != ST_IDLE);
    assign o_done          = (r_state == ST_DONE);
    assign o_return_total  = r_total;
    assign o_residue       = r_residue;
    assign o_wait_time     = r_timer;

endmodule : change_dispense_engine
`default_nettype wire

// File: tb/tb_change_dispense_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_change_dispense_engine
// Description : Self-checking bench for change_dispense_engine. Expected coin
//               sequences come from a value-based greedy change model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_change_dispense_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic [95:0] coin_value;
    logic [15:0] balance;
    logic        activity;
    logic        return_req;
    logic        busy;
    logic        done;
    logic [15:0] return_total;
    logic [15:0] residue;
    logic [31:0] wait_time;

    change_dispense_engine_if #(.IDX_W(2)) cif ();

    change_dispense_engine dut (
        .clk            (clk),
        .reset          (reset),
        .i_coin_value   (coin_value),
        .i_balance      (balance),
        .i_activity     (activity),
        .i_return_req   (return_req),
        .coin           (cif),
        .o_busy         (busy),
        .o_done         (done),
        .o_return_total (return_total),
        .o_residue      (residue),
        .o_wait_time    (wait_time)
    );

    always #5 clk = ~clk;

    int unsigned tbl [3];
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_table(input int unsigned a, input int unsigned b, input int unsigned c);
        tbl[0] = a; tbl[1] = b; tbl[2] = c;
        coin_value = {c, b, a};
    endtask

    // Starts a return with the button; the caller then calls run_dispense.
    task automatic trig_return(input logic [15:0] bal, input logic with_act);
        balance    = bal;
        return_req = 1'b1;
        activity   = with_act;
        tick();
        return_req = 1'b0;
        activity   = 1'b0;
        chk("trigger_busy", {31'd0, busy}, 32'd1);
        chk("trigger_timer_zero", wait_time, 32'd0);
    endtask

    // mode 0: ready always high; 1: random ready; 2: stall first offer 3 cycles
    task automatic run_dispense(input string tag, input int unsigned bal, input int mode);
        int unsigned exp_q[$];
        int unsigned rem;
        int unsigned exp_total;
        int          best;
        int          cyc;
        int          stalls;
        int          stall_left;
        int          coins;
        logic        r;
        logic        prev_stall;
        logic [1:0]  prev_idx;

        // Reference: repeatedly take the largest enabled coin value <= rest
        rem = bal;
        forever begin
            best = -1;
            for (int i = 0; i < 3; i++)
                if (tbl[i] != 0 && tbl[i] <= rem && (best < 0 || tbl[i] > tbl[best]))
                    best = i;
            if (best < 0) break;
            exp_q.push_back(best);
            rem -= tbl[best];
        end
        coins      = exp_q.size();
        exp_total  = bal - rem;
        cyc        = 0;
        stalls     = 0;
        stall_left = 3;
        prev_stall = 1'b0;
        prev_idx   = '0;

        while (!done && cyc < 300) begin
            activity = 1'($urandom % 2);   // must be ignored while busy
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_timer_held"}, wait_time, 32'd0);
            r = 1'($urandom % 2);
            if (mode == 0) r = 1'b1;
            if (prev_stall)
                chk({tag, "_offer_held"}, {31'd0, cif.coin_valid}, 32'd1);
            if (cif.coin_valid) begin
                chk({tag, "_idx"}, {30'd0, cif.coin_idx},
                    (exp_q.size() > 0) ? exp_q[0] : 32'd3);
                if (prev_stall)
                    chk({tag, "_idx_stable"}, {30'd0, cif.coin_idx}, {30'd0, prev_idx});
                if (mode == 2) begin
                    r = (stall_left > 0) ? 1'b0 : 1'b1;
                    if (stall_left > 0) stall_left--;
                end
                if (r && exp_q.size() > 0) void'(exp_q.pop_front());
                if (!r) stalls++;
                prev_stall = !r;
                prev_idx   = cif.coin_idx;
            end else begin
                prev_stall = 1'b0;
            end
            cif.coin_ready = r;
            tick();
            cyc++;
        end
        activity = 1'b0;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_latency"}, cyc, coins + stalls + 1);
        chk({tag, "_total"}, {16'd0, return_total}, exp_total);
        chk({tag, "_residue"}, {16'd0, residue}, rem);
        chk({tag, "_coins_left"}, exp_q.size(), 32'd0);
        chk({tag, "_valid_in_done"}, {31'd0, cif.coin_valid}, 32'd0);
        // Datapath settles the balance; residue is cleared by the bench.
        balance        = '0;
        cif.coin_ready = 1'b0;
        tick();
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_total_held"}, {16'd0, return_total}, exp_total);
        chk({tag, "_residue_held"}, {16'd0, residue}, rem);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, cif.coin_valid}, 32'd0);
        chk({tag, "_idx"}, {30'd0, cif.coin_idx}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_total"}, {16'd0, return_total}, 32'd0);
        chk({tag, "_residue"}, {16'd0, residue}, 32'd0);
        chk({tag, "_timer"}, wait_time, 32'd0);
    endtask

    initial begin
        int unsigned v0, v1, v2, b;

        reset          = 1'b1;
        balance        = '0;
        activity       = 1'b0;
        return_req     = 1'b0;
        cif.coin_ready = 1'b0;
        set_table(100, 500, 1000);
        tick();
        tick();
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Basic returns, ready tied high
        trig_return(16'd1600, 1'b0);
        run_dispense("bal1600", 1600, 0);

        // Backpressure on the first offer
        trig_return(16'd2200, 1'b0);
        run_dispense("bal2200_stall", 2200, 2);

        // Timeout trigger after one activity pulse
        balance  = 16'd500;
        activity = 1'b1;
        tick();
        activity = 1'b0;
        chk("timeout_load", wait_time, 32'd10);
        for (int i = 0; i < 9; i++) tick();
        chk("timeout_not_yet", {31'd0, busy}, 32'd0);
        chk("timeout_timer_one", wait_time, 32'd1);
        tick();
        chk("timeout_fired", {31'd0, busy}, 32'd1);
        run_dispense("timeout500", 500, 0);

        // Activity at timer==3 reloads
        balance  = 16'd600;
        activity = 1'b1;
        tick();
        activity = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("reload_timer3", wait_time, 32'd3);
        activity = 1'b1;
        tick();
        activity = 1'b0;
        chk("reload_timer10", wait_time, 32'd10);
        for (int i = 0; i < 9; i++) tick();
        chk("reload_not_at_3", {31'd0, busy}, 32'd0);
        tick();
        chk("reload_fired", {31'd0, busy}, 32'd1);
        run_dispense("reload600", 600, 0);

        // Residue, with return and activity in the same cycle
        trig_return(16'd1650, 1'b1);
        run_dispense("bal1650", 1650, 1);

        // Disabled smallest coin: nothing fits
        set_table(0, 500, 1000);
        trig_return(16'd300, 1'b0);
        run_dispense("nofit300", 300, 0);

        // Empty balance still walks through DONE
        set_table(100, 500, 1000);
        trig_return(16'd0, 1'b0);
        run_dispense("bal0", 0, 0);

        // Coin wider than the balance field must never be picked
        set_table(100, 500, 32'h0001_0064);
        trig_return(16'hFFFF, 1'b0);
        run_dispense("wide_coin", 32'hFFFF, 0);

        // Random ascending tables and balances, random ready
        for (int k = 0; k < 8; k++) begin
            v0 = $urandom_range(1, 60);
            v1 = v0 + $urandom_range(1, 200);
            v2 = v1 + $urandom_range(1, 900);
            b  = $urandom_range(0, 3000);
            set_table(v0, v1, v2);
            trig_return(16'(b), 1'b0);
            run_dispense("random", b, 1);
        end

        // Reset while the second coin is stalled
        set_table(100, 500, 1000);
        trig_return(16'd1600, 1'b0);
        cif.coin_ready = 1'b1;
        tick();
        cif.coin_ready = 1'b0;
        tick();
        chk("rst_mid_valid_before", {31'd0, cif.coin_valid}, 32'd1);
        chk("rst_mid_idx_before", {30'd0, cif.coin_idx}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        balance = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_mid_no_done", {31'd0, done}, 32'd0);
            chk("rst_mid_idle", {31'd0, busy}, 32'd0);
            chk("rst_mid_timer", wait_time, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_change_dispense_engine
`default_nettype wire
